// File: rtl/trig_sequencer.sv
// Sine/cosine sequencer: reduces a degree operand modulo 360 by repeated
// subtraction, looks it up in an external sine table and applies sign symmetry.
module trig_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op_cos,
    input  logic        neg,
    input  logic [11:0] angle,
    output logic [8:0]  lut_angle,
    input  logic        lut_sign,
    input  logic        lut_whole,
    input  logic [6:0]  lut_fraction,
    output logic        busy,
    output logic        done,
    output logic        sign,
    output logic        whole,
    output logic [6:0]  fraction
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REDUCE = 2'd1,
        S_LOOKUP = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [12:0] r_acc;
    logic [12:0] w_acc_nxt;
    logic        r_cos;
    logic        w_cos_nxt;
    logic        r_neg;
    logic        w_neg_nxt;
    logic        r_busy;
    logic        w_busy_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic        r_sign;
    logic        w_sign_nxt;
    logic        r_whole;
    logic        w_whole_nxt;
    logic [6:0]  r_fraction;
    logic [6:0]  w_fraction_nxt;

    // cos is even so the operand sign is dropped; a zero magnitude is never negative.
    function automatic logic result_sign(input logic tab_sign, input logic is_cos,
                                         input logic op_neg, input logic tab_whole,
                                         input logic [6:0] tab_frac);
        logic s;
        if (is_cos) begin
            s = tab_sign;
        end else begin
            s = tab_sign ^ op_neg;
        end
        if (!tab_whole && (tab_frac == 7'd0)) begin
            s = 1'b0;
        end else begin
            s = s;
        end
        return s;
    endfunction

    assign lut_angle = r_acc[8:0];
    assign busy      = r_busy;
    assign done      = r_done;
    assign sign      = r_sign;
    assign whole     = r_whole;
    assign fraction  = r_fraction;

    // Next-state and next-datapath values for the sequencer.
    always_comb begin
        w_state_nxt    = r_state;
        w_acc_nxt      = r_acc;
        w_cos_nxt      = r_cos;
        w_neg_nxt      = r_neg;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_sign_nxt     = r_sign;
        w_whole_nxt    = r_whole;
        w_fraction_nxt = r_fraction;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_acc_nxt   = {1'b0, angle} + (op_cos ? 13'd90 : 13'd0);
                    w_cos_nxt   = op_cos;
                    w_neg_nxt   = neg;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_REDUCE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_REDUCE: begin
                if (r_acc >= 13'd360) begin
                    w_acc_nxt   = r_acc - 13'd360;
                    w_state_nxt = S_REDUCE;
                end else begin
                    w_state_nxt = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                w_whole_nxt    = lut_whole;
                w_fraction_nxt = lut_fraction;
                w_sign_nxt     = result_sign(lut_sign, r_cos, r_neg, lut_whole, lut_fraction);
                w_done_nxt     = 1'b1;
                w_busy_nxt     = 1'b0;
                w_state_nxt    = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_acc      <= 13'd0;
            r_cos      <= 1'b0;
            r_neg      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sign     <= 1'b0;
            r_whole    <= 1'b0;
            r_fraction <= 7'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_acc      <= w_acc_nxt;
            r_cos      <= w_cos_nxt;
            r_neg      <= w_neg_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_sign     <= w_sign_nxt;
            r_whole    <= w_whole_nxt;
            r_fraction <= w_fraction_nxt;
        end
    end

endmodule

// File: tb/tb_trig_sequencer.sv
// Self-checking bench for trig_sequencer: models the sine table and checks
// latency, handshake and signed results against a modulo-arithmetic reference.
module tb_trig_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op_cos;
    logic        neg;
    logic [11:0] angle;
    logic [8:0]  lut_angle;
    logic        lut_sign;
    logic        lut_whole;
    logic [6:0]  lut_fraction;
    logic        busy;
    logic        done;
    logic        sign;
    logic        whole;
    logic [6:0]  fraction;

    int checks;
    int failures;

    trig_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op_cos       (op_cos),
        .neg          (neg),
        .angle        (angle),
        .lut_angle    (lut_angle),
        .lut_sign     (lut_sign),
        .lut_whole    (lut_whole),
        .lut_fraction (lut_fraction),
        .busy         (busy),
        .done         (done),
        .sign         (sign),
        .whole        (whole),
        .fraction     (fraction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sine table entry {sign, whole, hundredths}, truncated toward zero.
    function automatic logic [8:0] tab(input int a);
        real s;
        real m_r;
        int  m;
        logic sg;
        s  = $sin(real'(a) * 3.14159265358979323846 / 180.0);
        m_r = (s < 0.0) ? -s : s;
        m  = int'($floor(m_r * 100.0 + 1.0e-6));
        sg = (s < 0.0) && (m != 0);
        return {sg, (m >= 100) ? 1'b1 : 1'b0, 7'(m % 100)};
    endfunction

    logic [8:0] w_tab;
    always_comb begin
        w_tab        = tab(int'(lut_angle));
        lut_sign     = w_tab[8];
        lut_whole    = w_tab[7];
        lut_fraction = w_tab[6:0];
    end

    task automatic run_op(input logic c, input logic n, input logic [11:0] a,
                          input bit junk, input int ign_at);
        int tot, k, red, c_done;
        logic [8:0] t;
        logic es, ew;
        logic [6:0] ef;
        bit busy_ok;
        tot = int'(a) + (c ? 90 : 0);
        k   = tot / 360;
        red = tot % 360;
        t   = tab(red);
        ew  = t[7];
        ef  = t[6:0];
        es  = (c ? t[8] : (t[8] ^ n)) && !(ew == 1'b0 && ef == 7'd0);
        op_cos = c; neg = n; angle = a; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op_cos = 1'($urandom); neg = 1'($urandom); angle = 12'($urandom);
        busy_ok = (busy === 1'b1) && (done === 1'b0);
        c_done = 0;
        for (int cy = 1; cy <= 20 && c_done == 0; cy++) begin
            if (cy == ign_at) begin
                start = 1'b1; angle = 12'd30; op_cos = 1'b0;
            end
            @(posedge clk); #1;
            if (cy == ign_at) start = 1'b0;
            if (cy == k + 1) begin
                checks++;
                if (lut_angle !== 9'(red)) begin
                    failures++;
                    $display("FAIL lut_angle a=%0d cos=%0d got=%0d exp=%0d", a, c, lut_angle, red);
                end
            end
            if (done === 1'b1) c_done = cy;
            else if (busy !== 1'b1) busy_ok = 0;
        end
        checks++;
        if (c_done != k + 2) begin
            failures++;
            $display("FAIL latency a=%0d cos=%0d got=%0d exp=%0d (0=timeout)", a, c, c_done, k + 2);
        end
        checks++;
        if (!busy_ok || busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_window a=%0d busy_ok=%0d busy_at_done=%b exp_busy_at_done=0", a, busy_ok, busy);
        end
        checks++;
        if ({sign, whole, fraction} !== {es, ew, ef}) begin
            failures++;
            $display("FAIL result a=%0d cos=%0d neg=%0d got=%b/%b/%0d exp=%b/%b/%0d",
                     a, c, n, sign, whole, fraction, es, ew, ef);
        end
        if (junk) begin
            start = 1'b1; angle = 12'($urandom); op_cos = 1'($urandom);
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || {sign, whole, fraction} !== {es, ew, ef}) begin
            failures++;
            $display("FAIL after_done a=%0d junk=%0d got done=%b busy=%b res=%b/%b/%0d exp 0/0 %b/%b/%0d",
                     a, junk, done, busy, sign, whole, fraction, es, ew, ef);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op_cos = 1'b0; neg = 1'b0; angle = 12'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, sign, whole, fraction, lut_angle} !== 20'd0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0", {busy, done, sign, whole, fraction, lut_angle});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_op(1'b0, 1'b0, 12'd30, 1'b0, 0);
        checks++;
        if (fraction !== 7'd50 || whole !== 1'b0 || sign !== 1'b0) begin
            failures++;
            $display("FAIL sin30 got=%b/%b/%0d exp=0/0/50", sign, whole, fraction);
        end
        run_op(1'b1, 1'b0, 12'd0, 1'b0, 0);
        run_op(1'b1, 1'b1, 12'd60, 1'b0, 0);
        run_op(1'b0, 1'b0, 12'd750, 1'b0, 0);
        run_op(1'b0, 1'b0, 12'd360, 1'b0, 0);
        run_op(1'b0, 1'b1, 12'd210, 1'b0, 0);
        run_op(1'b0, 1'b1, 12'd180, 1'b0, 0);
        run_op(1'b0, 1'b1, 12'd270, 1'b1, 0);
    endtask

    task automatic test_start_ignored();
        run_op(1'b1, 1'b0, 12'd4095, 1'b0, 5);
        checks++;
        if (sign !== 1'b1 || fraction !== 7'd70) begin
            failures++;
            $display("FAIL cos4095 got=%b/%0d exp=1/70", sign, fraction);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL ignored_start_leak busy=%b done=%b exp 0/0", busy, done);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op(1'($urandom), 1'($urandom), 12'($urandom_range(4095, 0)),
                   ($urandom_range(3, 0) == 0), 0);
        end
    endtask

    task automatic test_reset_midop();
        bit seen;
        run_op(1'b0, 1'b0, 12'd90, 1'b0, 0);
        op_cos = 1'b0; neg = 1'b0; angle = 12'd4095; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, sign, whole, fraction, lut_angle} !== 20'd0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=0", {busy, done, sign, whole, fraction, lut_angle});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int cy = 0; cy < 15; cy++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL reset_discard got=activity exp=none");
        end
        run_op(1'b0, 1'b0, 12'd90, 1'b0, 0);
        checks++;
        if (whole !== 1'b1 || fraction !== 7'd0 || sign !== 1'b0) begin
            failures++;
            $display("FAIL sin90_after_reset got=%b/%b/%0d exp=0/1/0", sign, whole, fraction);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_start_ignored();
        test_random();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
